// File: rtl/aes_encipher_ctrl.sv
// ---------------------------------------------------------------------------
// aes_encipher_ctrl
//
// Sequencer for a combinational AES encipher round datapath. The block
// latches a plaintext, holds the 128-bit cipher state and walks it through
// the INIT, MAIN and FINAL rounds. It runs one round per clock cycle and
// registers the datapath result each time. AES-128 (10 rounds) and AES-256
// (14 rounds) are both supported.
//
// Ports
//   clk          system clock, rising-edge
//   reset_n      asynchronous active-low reset
//   next         start request, accepted only while ready=1
//   keylen       0 = AES-128, 1 = AES-256, sampled on acceptance
//   block        plaintext, sampled on acceptance
//   round        round index to the key memory
//   round_key    current round key (consumed by the datapath, not here)
//   round_type   0 INIT, 1 MAIN, 2 FINAL, 3 IDLE/no-op
//   state        current state register to the round datapath
//   state_new    datapath result for state/round_type/round_key
//   new_block    ciphertext (mirror of the state register)
//   ready        idle and able to accept next
//   result_valid new_block holds a completed ciphertext
//
// Timing: if next is accepted at edge T, ready rises at edge T+NR+1. That
// makes NR+1 datapath cycles with ready low.
// ---------------------------------------------------------------------------
module aes_encipher_ctrl #(
  parameter int NR_128 = 10,
  parameter int NR_256 = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [1:0]   round_type,
  output logic [127:0] state,
  input  logic [127:0] state_new,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         result_valid
);

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_INIT  = 2'd1,
    FSM_MAIN  = 2'd2,
    FSM_FINAL = 2'd3
  } fsm_t;

  localparam logic [1:0] RT_INIT  = 2'd0;
  localparam logic [1:0] RT_MAIN  = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;
  localparam logic [1:0] RT_IDLE  = 2'd3;

  localparam logic [3:0] NR_128_W = 4'(NR_128);
  localparam logic [3:0] NR_256_W = 4'(NR_256);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   ctr_q, ctr_d;
  logic         keylen_q, keylen_d;
  logic         ready_q, ready_d;
  logic         valid_q, valid_d;
  logic [3:0]   nr;

  // The round key is routed from the key memory straight into the datapath.
  // The controller only carries the port, so the bus is folded into a sink here.
  logic round_key_unused;
  assign round_key_unused = ^round_key;

  assign nr = keylen_q ? NR_256_W : NR_128_W;

  // NOTE: every register, including the 128-bit state, is reset. It is a
  // single register, not a memory array, and a defined value after reset
  // keeps a stale ciphertext from leaking out after an abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= FSM_IDLE;
      state_q  <= '0;
      ctr_q    <= '0;
      keylen_q <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from
      // the values of the previous cycle regardless of statement order.
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      keylen_q <= keylen_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and infers a latch.
    fsm_d      = fsm_q;
    state_d    = state_q;
    ctr_d      = ctr_q;
    keylen_d   = keylen_q;
    ready_d    = ready_q;
    valid_d    = valid_q;
    round      = 4'd0;
    round_type = RT_IDLE;

    unique case (fsm_q)
      FSM_IDLE: begin
        if (next) begin
          state_d  = block;
          keylen_d = keylen;
          ctr_d    = 4'd0;
          ready_d  = 1'b0;
          valid_d  = 1'b0;
          fsm_d    = FSM_INIT;
        end
      end

      FSM_INIT: begin
        round_type = RT_INIT;
        state_d    = state_new;
        ctr_d      = 4'd1;
        fsm_d      = FSM_MAIN;
      end

      FSM_MAIN: begin
        round_type = RT_MAIN;
        round      = ctr_q;
        state_d    = state_new;
        ctr_d      = ctr_q + 4'd1;
        if (ctr_q == nr - 4'd1) fsm_d = FSM_FINAL;
      end

      FSM_FINAL: begin
        round_type = RT_FINAL;
        round      = nr;
        state_d    = state_new;
        ready_d    = 1'b1;
        valid_d    = 1'b1;
        fsm_d      = FSM_IDLE;
      end

      default: begin
        // Unreachable with a 2-bit encoding. Kept so any corruption
        // falls back to a usable idle controller.
        fsm_d   = FSM_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign state        = state_q;
  assign new_block    = state_q;
  assign ready        = ready_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_aes_encipher_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_encipher_ctrl
//
// Bench for the AES encipher sequencer. A stand-in round datapath and key
// memory respond combinationally to round/round_type/state. The round
// functions are cheap, keyed and non-commutative, so any wrong ordering,
// missing round or extra round changes the result. A plain loop over the
// round schedule predicts every ciphertext.
// ---------------------------------------------------------------------------
module tb_aes_encipher_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [127:0] block;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [1:0]   round_type;
  logic [127:0] state;
  logic [127:0] state_new;
  logic [127:0] new_block;
  logic         ready;
  logic         result_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] key_mem [0:15];

  always #5 clk = ~clk;

  aes_encipher_ctrl #(.NR_128(10), .NR_256(14)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .next         (next),
    .keylen       (keylen),
    .block        (block),
    .round        (round),
    .round_key    (round_key),
    .round_type   (round_type),
    .state        (state),
    .state_new    (state_new),
    .new_block    (new_block),
    .ready        (ready),
    .result_valid (result_valid)
  );

  // ---------------- stand-in datapath and key memory ----------------
  function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
    return (x << n) | (x >> (128 - n));
  endfunction

  function automatic logic [127:0] main_round(input logic [127:0] s, input logic [127:0] k);
    return (rotl(s, 7) ^ k) + 128'h9e3779b9_7f4a7c15_f39cc060_5cedc834;
  endfunction

  function automatic logic [127:0] final_round(input logic [127:0] s, input logic [127:0] k);
    return rotl(s, 13) ^ k ^ 128'hffff0000_ffff0000_ffff0000_ffff0000;
  endfunction

  assign round_key = key_mem[round];

  always_comb begin
    case (round_type)
      2'd0:    state_new = state ^ round_key;
      2'd1:    state_new = main_round(state, round_key);
      2'd2:    state_new = final_round(state, round_key);
      default: state_new = ~state;   // a write during IDLE would be visible
    endcase
  end

  // ---------------- reference model ----------------
  function automatic int nr_of(input logic kl);
    return kl ? 14 : 10;
  endfunction

  function automatic logic [127:0] encipher(input logic kl, input logic [127:0] blk);
    logic [127:0] s;
    int nr;
    nr = nr_of(kl);
    s = blk ^ key_mem[0];
    for (int r = 1; r < nr; r++) s = main_round(s, key_mem[r]);
    return final_round(s, key_mem[nr]);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse next for one cycle and follow the run edge by edge. The whole
  // round schedule and the final result are compared.
  task automatic run_vector(input logic kl, input logic [127:0] blk, input logic [127:0] exp);
    int nr;
    logic [1:0] exp_type;
    logic [3:0] exp_round;
    nr = nr_of(kl);
    next   = 1'b1;
    keylen = kl;
    block  = blk;
    tick();
    // While busy the inputs wander, and the DUT must not resample them.
    next   = 1'b0;
    keylen = ~kl;
    block  = rand128();
    for (int i = 0; i <= nr; i++) begin
      exp_round = 4'(i);
      exp_type  = (i == 0) ? 2'd0 : (i == nr) ? 2'd2 : 2'd1;
      check("busy_sequence", {120'd0, ready, result_valid, round_type, round},
            {120'd0, 1'b0, 1'b0, exp_type, exp_round});
      tick();
    end
    check("done_flags", {126'd0, ready, result_valid}, {126'd0, 2'b11});
    check("done_idle_outputs", {122'd0, round_type, round}, {122'd0, 2'd3, 4'd0});
    check("ciphertext", new_block, exp);
    check("state_mirror", state, exp);
  endtask

  typedef struct {
    logic         kl;
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] blk_a, blk_b, last_exp;
    logic         kl_a, kl_b, found;
    int           cycles;

    for (int i = 0; i < 16; i++) key_mem[i] = rand128();
    key_mem[0] = 128'h00010203_04050607_08090a0b_0c0d0e0f;

    next    = 1'b0;
    keylen  = 1'b0;
    block   = '0;
    reset_n = 1'b0;
    #12;
    check("reset_flags", {126'd0, ready, result_valid}, {126'd0, 2'b10});
    check("reset_state", state, '0);
    check("reset_round", {122'd0, round_type, round}, {122'd0, 2'd3, 4'd0});
    reset_n = 1'b1;
    tick();
    tick();
    check("idle_holds_state", new_block, '0);

    // ---- table-driven runs ----
    vecs[0].kl = 1'b0; vecs[0].blk = 128'h00112233_44556677_8899aabb_ccddeeff;
    vecs[1].kl = 1'b1; vecs[1].blk = 128'h00112233_44556677_8899aabb_ccddeeff;
    vecs[2].kl = 1'b0; vecs[2].blk = '0;
    vecs[3].kl = 1'b1; vecs[3].blk = '1;
    vecs[4].kl = 1'b0; vecs[4].blk = rand128();
    vecs[5].kl = 1'b1; vecs[5].blk = rand128();
    for (int i = 0; i < 6; i++) vecs[i].exp = encipher(vecs[i].kl, vecs[i].blk);

    // Runs go back to back. Each next lands on the first ready cycle.
    for (int i = 0; i < 6; i++) run_vector(vecs[i].kl, vecs[i].blk, vecs[i].exp);

    // ---- randomized runs with random idle gaps ----
    for (int i = 0; i < 8; i++) begin
      kl_a  = 1'($urandom);
      blk_a = rand128();
      repeat ($urandom_range(0, 3)) tick();
      run_vector(kl_a, blk_a, encipher(kl_a, blk_a));
      last_exp = encipher(kl_a, blk_a);
    end

    // ---- result stays put while idle ----
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_stable_block", new_block, last_exp);
      check("idle_stable_flags", {124'd0, ready, result_valid, round_type},
            {124'd0, 1'b1, 1'b1, 2'd3});
    end

    // ---- next held high with inputs changing throughout ----
    kl_a  = 1'b0;
    blk_a = rand128();
    next   = 1'b1;
    keylen = kl_a;
    block  = blk_a;
    tick();
    check("held_accept_drops_valid", {126'd0, ready, result_valid}, {126'd0, 2'b00});
    found = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) begin found = 1'b1; break; end
      keylen = 1'($urandom);
      block  = rand128();
      cycles++;
      tick();
    end
    check("held_first_done", {127'd0, found}, {127'd0, 1'b1});
    check("held_first_latency", 128'(cycles), 128'(nr_of(kl_a) + 1));
    check("held_first_result", new_block, encipher(kl_a, blk_a));
    kl_b  = keylen;
    blk_b = block;
    tick();
    check("held_second_accepted", {127'd0, ready}, {127'd0, 1'b0});
    found = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) begin found = 1'b1; break; end
      keylen = 1'($urandom);
      block  = rand128();
      cycles++;
      tick();
    end
    next = 1'b0;
    check("held_second_done", {127'd0, found}, {127'd0, 1'b1});
    check("held_second_latency", 128'(cycles), 128'(nr_of(kl_b) + 1));
    check("held_second_result", new_block, encipher(kl_b, blk_b));
    tick();

    // ---- reset asserted during MAIN round 5 ----
    next   = 1'b1;
    keylen = 1'b0;
    block  = vecs[0].blk;
    tick();
    next = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (round == 4'd5 && round_type == 2'd1) begin found = 1'b1; break; end
      tick();
    end
    check("reached_round5", {127'd0, found}, {127'd0, 1'b1});
    #2 reset_n = 1'b0;
    #1;
    check("abort_flags", {126'd0, ready, result_valid}, {126'd0, 2'b10});
    check("abort_state", state, '0);
    check("abort_round", {122'd0, round_type, round}, {122'd0, 2'd3, 4'd0});
    tick();
    reset_n = 1'b1;
    tick();
    check("abort_idle_state", new_block, '0);
    run_vector(vecs[0].kl, vecs[0].blk, vecs[0].exp);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
